voq_bank: RTL

//  - Bank of NUM_Q independent virtual output queues holding packet-buffer pointers, one queue per egress port.
//  - Sits between ingress lookup (enqueue by destination) and egress scheduler (dequeue by selected queue).
//  - Adds per-queue occupancy/full/empty status, full-queue drop accounting and per-queue flush.

---
 rtl/voq_bank.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/voq_bank.sv
// Bank of NUM_Q independent pointer FIFOs (virtual output queues), one per egress port.
// Enqueue by destination, dequeue by scheduler-selected queue, per-queue flush and drop accounting.

module voq_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] wr_ptr_i,
  output logic [ADDR_W-1:0] head_o,
  output logic              rd_ok_o,
  output logic              wr_drop_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int IDX_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              wr_ok, rd_ok;

  always_comb begin
    // A full queue still takes a write when the same-cycle read frees a slot.
    rd_ok    = rd_i && !flush_i && (count_q != '0);
    wr_ok    = wr_i && !flush_i && ((count_q != FULL_CNT) || rd_ok);
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_idx_d = wr_idx_q + 1'b1;
      if (rd_ok) rd_idx_d = rd_idx_q + 1'b1;
      count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_idx_q] <= wr_ptr_i;
  end

  assign head_o    = mem_q[rd_idx_q];
  assign rd_ok_o   = rd_ok;
  assign wr_drop_o = wr_i && !flush_i && !wr_ok;
  assign count_o   = count_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;
endmodule

module voq_bank #(
  parameter int NUM_Q  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10,
  parameter int DROP_W = 16,
  localparam int QID_W = $clog2(NUM_Q),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [QID_W-1:0]       wr_q_i,
  input  logic [ADDR_W-1:0]      wr_ptr_i,
  input  logic                   rd_en_i,
  input  logic [QID_W-1:0]       rd_q_i,
  input  logic [NUM_Q-1:0]       flush_i,
  output logic [ADDR_W-1:0]      rd_ptr_o,
  output logic                   rd_valid_o,
  output logic                   wr_drop_o,
  output logic [NUM_Q-1:0]       empty_o,
  output logic [NUM_Q-1:0]       full_o,
  output logic [NUM_Q*CNT_W-1:0] count_o,
  output logic [DROP_W-1:0]      drop_cnt_o
);
  logic [NUM_Q-1:0]             wr_sel, rd_sel, rd_ok, q_drop;
  logic [NUM_Q-1:0][ADDR_W-1:0] head;
  logic [NUM_Q-1:0][CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  for (genvar q = 0; q < NUM_Q; q++) begin : g_q
    // Out-of-range queue ids select no queue at all.
    assign wr_sel[q] = wr_en_i && (int'(wr_q_i) == q);
    assign rd_sel[q] = rd_en_i && (int'(rd_q_i) == q);

    voq_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (wr_sel[q]),
      .rd_i      (rd_sel[q]),
      .flush_i   (flush_i[q]),
      .wr_ptr_i  (wr_ptr_i),
      .head_o    (head[q]),
      .rd_ok_o   (rd_ok[q]),
      .wr_drop_o (q_drop[q]),
      .count_o   (cnt[q]),
      .empty_o   (empty_o[q]),
      .full_o    (full_o[q])
    );
  end

  always_comb begin
    rd_valid_d = |rd_ok;
    rd_ptr_d   = rd_ptr_q;
    for (int q = 0; q < NUM_Q; q++) begin
      if (rd_ok[q]) rd_ptr_d = head[q];
    end
    wr_drop_d  = (wr_en_i && !(|wr_sel)) || (|q_drop);
    drop_cnt_d = drop_cnt_q;
    if (wr_drop_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      wr_drop_q  <= wr_drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rd_ptr_o   = rd_ptr_q;
  assign rd_valid_o = rd_valid_q;
  assign wr_drop_o  = wr_drop_q;
  assign drop_cnt_o = drop_cnt_q;
  assign count_o    = cnt;
endmodule
